ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 4096x16 banked RAM (one bidirectional 16-bit data bus, rw=1 write / rw=0 read).
- Accepts single-word read/write requests from two masters, e.g. a CPU-side port and a DMA/test port.
- Grants the RAM to one master at a time under round-robin priority.
- Drives the RAM address, rw and write data for a fixed number of cycles, then returns read data and a completion pulse.
- Inserts a turnaround cycle between transactions so the shared data bus never has two drivers.

Parameters:
- WR_CYC, 2, cycles mem_rw/mem_addr/mem_wdata are held for a write (range 1..15)
- RD_LAT, 2, cycles from read address presentation to valid mem_rdata (range 1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  transaction request from master 0 / 1
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN high
- addr0 / addr1  in  12  word address; valid while reqN high
- wdata0 / wdata1  in  16  write data; valid while reqN and weN high
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs latched
- ack0 / ack1  out  1  one-cycle pulse: transaction complete
- rdata0 / rdata1  out  16  read result; valid from ackN, held until that master's next read completes
- busy  out  1  high whenever state is not IDLE
- mem_addr  out  12  RAM address
- mem_rw  out  1  RAM rw (1 = write, 0 = read)
- mem_wen  out  1  tri-state enable for mem_wdata onto the RAM data bus; high only in WR
- mem_wdata  out  16  write data toward the RAM bus
- mem_rdata  in  16  RAM data bus as seen by the controller

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - state = IDLE
  - gnt0/1, ack0/1, busy, mem_rw, mem_wen = 0
  - mem_addr, mem_wdata, rdata0, rdata1 = 0
  - priority pointer favours master 0
  - cycle counter = 0
- Reset mid-transaction: the transaction is dropped with no ack; mem_wen drops in the cycle after the reset edge.
- States: IDLE, WR, RD, DONE.
- IDLE:
  - If neither req is high, remain in IDLE.
  - If one req is high, select that master.
  - If both are high, select the master the pointer favours.
  - At the clock edge: latch the selected master's addr/we/wdata into mem_addr/mem_wdata; pulse its gnt for exactly the next cycle; load counter with WR_CYC or RD_LAT; go to WR (we=1) or RD (we=0).
  - Pointer then favours the other master.
- WR: mem_rw=1, mem_wen=1; mem_addr and mem_wdata stable; counter decrements each cycle; go to DONE after exactly WR_CYC cycles.
- RD: mem_rw=0, mem_wen=0; mem_addr stable; after exactly RD_LAT cycles, capture mem_rdata into the granted master's rdata on the final RD edge; go to DONE.
- DONE (one cycle):
  - mem_rw=0, mem_wen=0; this is the bus turnaround cycle.
  - Granted master's ack=1; for reads, rdata is already updated in this cycle.
  - Return to IDLE. Requests are never evaluated in DONE.
- Timing, with a request sampled in IDLE at cycle c:
  - gnt at c+1
  - write ack at c+WR_CYC+1; read ack at c+RD_LAT+1
  - next possible gnt at c+WR_CYC+3 (write) or c+RD_LAT+3 (read)
- busy = 1 in WR, RD and DONE.
- Master inputs are sampled only in IDLE. Changing addr/we/wdata after gnt has no effect on the transaction.
- A req held high after gnt is a new request; back-to-back transactions from both masters alternate.
- A req dropped before being sampled in IDLE produces no gnt.
- Never: gnt0 and gnt1 together, ack0 and ack1 together, or mem_wen high outside WR.
- No address checks: all 4096 addresses are legal, and bank select is the RAM's job.
- Counter is 4 bits and counts down to 1; parameter value 0 is illegal.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, busy=0, mem_wen never 1.
- Master 0 writes 16'hA5C3 to 12'h3FF (last word of bank 0). Master 0 then reads 12'h3FF -> gnt0 one cycle after req; write ack0 at WR_CYC+1; read ack0 at RD_LAT+1 with rdata0=16'hA5C3.
- Master 1 writes 16'h1234 to 12'h400, 16'h5678 to 12'h800 and 16'h9ABC to 12'hC00, then reads all three -> returns 16'h1234, 16'h5678, 16'h9ABC; rdata1 holds 16'h9ABC afterwards.
- req0 and req1 asserted in the same cycle and held for 4 transactions each -> grant order 0,1,0,1,...; never two gnt or two ack in the same cycle; gap between successive gnts = WR_CYC+2 (writes).
- Master 0 read followed immediately by master 1 write -> mem_wen=0 for the full read and the DONE cycle; no cycle has mem_wen=1 while mem_rw=0.
- rst asserted in the second WR cycle -> no ack; busy=0 and mem_wen=0 after the reset edge; a fresh req0 read is granted normally after rst is released.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Bundle of the two master request ports and the RAM-side bus of ram_access_arbiter.
// The arbiter connects through the slave modport; requesters use the master modport.
interface ram_access_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        ack0;
    logic        ack1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        busy;
    logic [11:0] mem_addr;
    logic        mem_rw;
    logic        mem_wen;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy,
               mem_addr, mem_rw, mem_wen, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, busy
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin two-master arbiter and access sequencer for the 4096x16 RAM.
// All outputs are registered from the next-state values; DONE doubles as the bus turnaround cycle.
module ram_access_arbiter #(
    parameter int WR_CYC = 2,
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_access_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, DONE = 2'd3} state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        ptr_r, ptr_s;
    logic        sel_r, sel_s;
    logic        pick_s, pick_we_s;
    logic [11:0] addr_s;
    logic [15:0] wdata_s, rdata0_s, rdata1_s;
    logic        gnt0_s, gnt1_s, ack0_s, ack1_s;

    // Next-state, next-output and arbitration decision
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        ptr_s     = ptr_r;
        sel_s     = sel_r;
        addr_s    = bus.mem_addr;
        wdata_s   = bus.mem_wdata;
        rdata0_s  = bus.rdata0;
        rdata1_s  = bus.rdata1;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        ack0_s    = 1'b0;
        ack1_s    = 1'b0;
        pick_s    = (bus.req0 && bus.req1) ? ptr_r : bus.req1;
        pick_we_s = pick_s ? bus.we1 : bus.we0;
        case (state_r)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_s   = pick_s;
                    ptr_s   = ~pick_s;
                    addr_s  = pick_s ? bus.addr1 : bus.addr0;
                    wdata_s = pick_s ? bus.wdata1 : bus.wdata0;
                    gnt0_s  = ~pick_s;
                    gnt1_s  = pick_s;
                    cnt_s   = pick_we_s ? 4'(WR_CYC) : 4'(RD_LAT);
                    state_s = pick_we_s ? WR : RD;
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                if (cnt_r == 4'd1) begin
                    cnt_s   = 4'd0;
                    ack0_s  = ~sel_r;
                    ack1_s  = sel_r;
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            RD: begin
                // Data is captured on the final RD edge so it is already visible with ack
                if (cnt_r == 4'd1) begin
                    cnt_s   = 4'd0;
                    ack0_s  = ~sel_r;
                    ack1_s  = sel_r;
                    state_s = DONE;
                    if (sel_r) begin
                        rdata1_s = bus.mem_rdata;
                    end else begin
                        rdata0_s = bus.mem_rdata;
                    end
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 4'd0;
            ptr_r         <= 1'b0;
            sel_r         <= 1'b0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mem_rw    <= 1'b0;
            bus.mem_wen   <= 1'b0;
            bus.mem_addr  <= 12'd0;
            bus.mem_wdata <= 16'd0;
            bus.rdata0    <= 16'd0;
            bus.rdata1    <= 16'd0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            ptr_r         <= ptr_s;
            sel_r         <= sel_s;
            bus.gnt0      <= gnt0_s;
            bus.gnt1      <= gnt1_s;
            bus.ack0      <= ack0_s;
            bus.ack1      <= ack1_s;
            bus.busy      <= (state_s != IDLE);
            bus.mem_rw    <= (state_s == WR);
            bus.mem_wen   <= (state_s == WR);
            bus.mem_addr  <= addr_s;
            bus.mem_wdata <= wdata_s;
            bus.rdata0    <= rdata0_s;
            bus.rdata1    <= rdata1_s;
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: stimulus queues expected grants and completions,
// a negedge monitor pops and compares them; a small RAM model with read latency sits on the bus.
module tb_ram_access_arbiter;
    localparam int WR_CYC = 2;
    localparam int RD_LAT = 3;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    ram_access_arbiter_if bus();

    ram_access_arbiter #(.WR_CYC(WR_CYC), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    bit   contend = 1'b0;
    int   rd_age = 0;
    int   gq[$];
    exp_t exp0[$];
    exp_t exp1[$];
    logic [15:0] mem [0:4095];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: writes on enabled edges, read data valid only after RD_LAT cycles of address
    always @(posedge clk) begin
        if (bus.mem_wen && bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.busy && !bus.mem_rw) rd_age <= rd_age + 1;
        else rd_age <= 0;
    end
    assign bus.mem_rdata = (!bus.mem_rw && rd_age >= RD_LAT - 1) ? mem[bus.mem_addr] : 16'hBAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    int last_gnt = -1;
    int gnt_cyc  = 0;

    task automatic handle_ack(input int m, input logic [15:0] rd);
        exp_t e;
        if ((m == 0 && exp0.size() == 0) || (m == 1 && exp1.size() == 0)) begin
            fail_now(m == 0 ? "unexpected_ack0" : "unexpected_ack1");
        end else begin
            e = (m == 0) ? exp0.pop_front() : exp1.pop_front();
            chk("ack_latency", 32'(cyc - gnt_cyc), e.we ? 32'(WR_CYC) : 32'(RD_LAT));
            if (!e.we) chk(m == 0 ? "rdata0" : "rdata1", {16'd0, rd}, {16'd0, e.data});
        end
        chk("wen_in_done", {31'd0, bus.mem_wen}, 32'd0);
    endtask

    // Monitor: invariants every cycle, grants and completions against the scoreboard
    always @(negedge clk) begin
        if (!contend) last_gnt = -1;
        if (mon_en && !rst) begin
            chk("two_gnt", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
            chk("two_ack", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            chk("wen_without_rw", {31'd0, bus.mem_wen & ~bus.mem_rw}, 32'd0);
            if (bus.gnt0 || bus.gnt1) begin
                if (gq.size() == 0) fail_now("unexpected_gnt");
                else chk("gnt_order", {31'd0, bus.gnt1}, 32'(gq.pop_front()));
                if (contend && last_gnt >= 0) chk("gnt_gap", 32'(cyc - last_gnt), 32'(WR_CYC + 2));
                last_gnt = cyc;
                gnt_cyc  = cyc;
            end
            if (bus.ack0) handle_ack(0, bus.rdata0);
            if (bus.ack1) handle_ack(1, bus.rdata1);
        end
    end

    task automatic drive(input int m, input bit req, input bit we, input logic [11:0] a, input logic [15:0] d);
        if (m == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Issue one request, wait for its grant, scramble the inputs, optionally wait for ack
    task automatic issue(input int m, input bit we, input logic [11:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input bit wait_ack, input bit push_exp,
                         output int waited);
        exp_t e;
        bit got;
        e.we = we;
        e.data = exp_rd;
        gq.push_back(m);
        if (push_exp) begin
            if (m == 0) exp0.push_back(e);
            else exp1.push_back(e);
        end
        drive(m, 1'b1, we, a, d);
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if ((m == 0) ? bus.gnt0 : bus.gnt1) begin
                got = 1'b1;
                waited = i;
                break;
            end
        end
        if (!got) fail_now("gnt_timeout");
        drive(m, 1'b0, ~we, ~a, ~d);
        if (wait_ack) begin
            got = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if ((m == 0) ? bus.ack0 : bus.ack1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) fail_now("ack_timeout");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0 && !bus.busy) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int c0, c1;
        exp_t e;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 12'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 12'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            chk("idle_ctl", {25'd0, bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.busy, bus.mem_rw, bus.mem_wen}, 32'd0);
            chk("idle_bus", {4'd0, bus.mem_addr, bus.mem_wdata}, 32'd0);
            chk("idle_rdata", {bus.rdata0, bus.rdata1}, 32'd0);
            @(posedge clk); #1;
        end

        // Master 0 write then read of the last word of bank 0
        issue(0, 1'b1, 12'h3FF, 16'hA5C3, 16'h0000, 1'b1, 1'b1, w);
        chk("gnt_delay_wr", 32'(w), 32'd0);
        issue(0, 1'b0, 12'h3FF, 16'h0000, 16'hA5C3, 1'b1, 1'b1, w);
        chk("gnt_delay_rd", 32'(w), 32'd1);

        // Master 1 writes and reads three banks
        issue(1, 1'b1, 12'h400, 16'h1234, 16'h0000, 1'b1, 1'b1, w);
        issue(1, 1'b1, 12'h800, 16'h5678, 16'h0000, 1'b1, 1'b1, w);
        issue(1, 1'b1, 12'hC00, 16'h9ABC, 16'h0000, 1'b1, 1'b1, w);
        issue(1, 1'b0, 12'h400, 16'h0000, 16'h1234, 1'b1, 1'b1, w);
        issue(1, 1'b0, 12'h800, 16'h0000, 16'h5678, 1'b1, 1'b1, w);
        issue(1, 1'b0, 12'hC00, 16'h0000, 16'h9ABC, 1'b1, 1'b1, w);
        repeat (3) @(posedge clk); #1;
        chk("rdata1_hold", {16'd0, bus.rdata1}, 32'h0000_9ABC);

        // Both masters held requesting: four writes each, strict alternation
        e.we = 1'b1;
        e.data = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(0);
            gq.push_back(1);
            exp0.push_back(e);
            exp1.push_back(e);
        end
        c0 = 0;
        c1 = 0;
        contend = 1'b1;
        drive(0, 1'b1, 1'b1, 12'h010, 16'h1000);
        drive(1, 1'b1, 1'b1, 12'h020, 16'h2000);
        for (int i = 0; i < 200 && (c0 < 4 || c1 < 4); i++) begin
            @(posedge clk); #1;
            if (bus.gnt0) begin
                c0++;
                drive(0, c0 < 4, 1'b1, 12'h010 + 12'(c0), 16'h1000 + 16'(c0));
            end
            if (bus.gnt1) begin
                c1++;
                drive(1, c1 < 4, 1'b1, 12'h020 + 12'(c1), 16'h2000 + 16'(c1));
            end
        end
        chk("contend_gnts", 32'(c0 + c1), 32'd8);
        contend = 1'b0;
        wait_drain();

        // Master 0 read with master 1 write queued behind it
        issue(0, 1'b0, 12'h013, 16'h0000, 16'h1003, 1'b0, 1'b1, w);
        issue(1, 1'b1, 12'h030, 16'h7777, 16'h0000, 1'b1, 1'b1, w);
        issue(1, 1'b0, 12'h022, 16'h0000, 16'h2002, 1'b1, 1'b1, w);
        wait_drain();

        // Reset in the second WR cycle drops the transaction
        issue(0, 1'b1, 12'h050, 16'hFFFF, 16'h0000, 1'b0, 1'b0, w);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ctl", {28'd0, bus.ack0, bus.ack1, bus.busy, bus.mem_wen}, 32'd0);
        chk("rst_rdata0", {16'd0, bus.rdata0}, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", {30'd0, bus.ack0, bus.busy}, 32'd0);
        end
        issue(0, 1'b0, 12'h3FF, 16'h0000, 16'hA5C3, 1'b1, 1'b1, w);
        chk("post_rst_gnt_delay", 32'(w), 32'd0);
        wait_drain();

        chk("scoreboard_empty", 32'(exp0.size() + exp1.size() + gq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
